// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: round-robin framing arbiter sharing one uart_tx between byte-stream sources
module uart_frame_scheduler #(
   parameter int         NUM_SRC   = 2,
   parameter logic [7:0] SYNC_BYTE = 8'h7E
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [8*NUM_SRC-1:0] req_data,
   input  logic [NUM_SRC-1:0]   req_valid,
   input  logic [NUM_SRC-1:0]   req_last,
   output logic [NUM_SRC-1:0]   req_ready,
   output logic [NUM_SRC-1:0]   grant,
   output logic                 busy,
   output logic [7:0]           uart_byte,
   output logic                 uart_send,
   input  logic                 uart_ready
);
   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [3:0] {
      IDLE, HDR_I, HDR_W, ID_I, ID_W, DATA_I, DATA_W, CSUM_I, CSUM_W
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   g, rr_ptr, sel;
   logic            found, last_seen, fire, valid_g;
   logic [7:0]      csum, byte_g, id_byte;

   assign valid_g = req_valid[g];
   assign byte_g  = req_data[8*int'(g) +: 8];
   assign id_byte = {{(8-IW){1'b0}}, g};
   assign fire    = uart_ready & ((state == HDR_I) | (state == ID_I) | (state == CSUM_I) |
                                  ((state == DATA_I) & valid_g));

   // round-robin pick: descending scan so the nearest requester after rr_ptr wins
   always_comb begin
      sel   = rr_ptr;
      found = 1'b0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         if (req_valid[IW'((int'(rr_ptr) + k) % NUM_SRC)]) begin
            sel   = IW'((int'(rr_ptr) + k) % NUM_SRC);
            found = 1'b1;
         end
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state: each byte issues only when uart_tx is ready, then waits for ready to return
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = found ? HDR_I : IDLE;
         HDR_I:   state_nxt = fire ? HDR_W : HDR_I;
         HDR_W:   state_nxt = uart_ready ? ID_I : HDR_W;
         ID_I:    state_nxt = fire ? ID_W : ID_I;
         ID_W:    state_nxt = uart_ready ? DATA_I : ID_W;
         DATA_I:  state_nxt = fire ? DATA_W : DATA_I;
         DATA_W:  state_nxt = uart_ready ? (last_seen ? CSUM_I : DATA_I) : DATA_W;
         CSUM_I:  state_nxt = fire ? CSUM_W : CSUM_I;
         CSUM_W:  state_nxt = uart_ready ? IDLE : CSUM_W;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs: send and source handshake exist only in issue phases
   always_comb begin
      req_ready    = '0;
      req_ready[g] = (state == DATA_I) & uart_ready;
      uart_send    = fire;
      busy         = (state != IDLE);
      uart_byte    = ((state == HDR_I)  | (state == HDR_W))  ? SYNC_BYTE :
                     ((state == ID_I)   | (state == ID_W))   ? id_byte   :
                     ((state == DATA_I) | (state == DATA_W)) ? byte_g    :
                     ((state == CSUM_I) | (state == CSUM_W)) ? csum      : 8'h00;
   end

   // frame owner, running checksum, last-byte flag and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g         <= '0;
         grant     <= '0;
         csum      <= 8'h00;
         last_seen <= 1'b0;
         rr_ptr    <= IW'(NUM_SRC - 1);
      end else begin
         if (state == IDLE && found) begin
            g     <= sel;
            grant <= NUM_SRC'(1) << sel;
            csum  <= 8'h00;
         end
         if (state == ID_I && fire) csum <= id_byte;
         if (state == DATA_I && fire) begin
            csum      <= csum ^ byte_g;
            last_seen <= req_last[g];
         end
         if (state == CSUM_W && uart_ready) begin
            rr_ptr <= g;
            grant  <= '0;
         end
      end
   end
endmodule
